sr_flag_sched: RTL and testbench
================================

SR_FLAG_SCHED -- requirements
Module: sr_flag_sched

Parameters
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter NFLAG, default 8, meaning the number of managed set/reset flags.
REQ-003 The block SHALL have parameter IW, default $clog2(NFLAG), meaning the width of the flag index.

Interface
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NREQ  per-requester request; bit i belongs to requester i.
REQ-007 op  input  2*NREQ  per-requester opcode; requester i uses bits [2i+1:2i].
REQ-008 idx  input  IW*NREQ  per-requester target flag index; requester i uses bits [IW*i+IW-1:IW*i].
REQ-009 clr_all  input  1  global clear of all flags; it has priority over any requester operation.
REQ-010 gnt  output  NREQ  one-hot grant, high for exactly one cycle per accepted transaction.
REQ-011 flags  output  NFLAG  registered flag bank.
REQ-012 flags_n  output  NFLAG  bitwise complement of flags.
REQ-013 busy  output  1  high while a transaction is granted (state GRANT).

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and GRANT.
REQ-015 IDLE->GRANT: at a rising edge in IDLE with clr_all=0 and any req bit set, the FSM SHALL capture the round-robin winner plus its op and idx.
REQ-016 GRANT->IDLE: the FSM SHALL move to IDLE unconditionally on the next edge, applying the captured op to flags on that edge.
REQ-017 Latency: with req sampled at edge E0, gnt SHALL be high during the cycle E0..E1 and the flag change SHALL be visible after E1.
REQ-018 Throughput SHALL be at most one transaction per two cycles.
REQ-019 gnt SHALL be decoded from the state and the captured winner only, and SHALL be zero in IDLE.
REQ-020 Round-robin SHALL search upward, modulo NREQ, starting at ptr.
REQ-021 ptr SHALL become winner+1 (mod NREQ) only when a grant is issued.
REQ-022 Op encoding SHALL be: 00 hold (granted, no change), 01 clear flag, 10 set flag, 11 toggle flag. The simultaneous S/R case is therefore always defined and never yields X.
REQ-023 An idx >= NFLAG SHALL be granted and SHALL leave all flags unchanged.
REQ-024 req bits SHALL be ignored while in GRANT; only IDLE edges sample requests.
REQ-025 A requester still holding req in the IDLE cycle after its gnt SHALL be treated as a new request, lowest priority under round-robin.
REQ-026 clr_all=1 at any edge SHALL set flags to 0.
REQ-027 If clr_all coincides with the GRANT->IDLE edge, the captured op SHALL be discarded. gnt was still issued for that cycle.
REQ-028 If clr_all=1 at an IDLE edge, no request SHALL be captured and ptr SHALL be unchanged.
REQ-029 flags_n SHALL always equal ~flags, including during reset.

Reset
REQ-030 While rst_n=0, the block SHALL hold: state=IDLE, flags=0, flags_n=all ones, gnt=0, busy=0, ptr=0, captured op/idx/winner=0.
REQ-031 Reset asserted mid-GRANT SHALL abort the transaction immediately, with no flag update.
REQ-032 The first request sampled after rst_n deasserts SHALL be arbitrated starting from requester 0.

Structure
REQ-033 A shared package SHALL hold: the op encoding constants (OP_HOLD, OP_CLR, OP_SET, OP_TGL) and the state enum (IDLE, GRANT).
REQ-034 Round-robin selection SHALL be a combinational sub-module sr_rr_arbiter (inputs req, ptr; outputs one-hot winner, any).
REQ-035 The flag bank SHALL be NFLAG independent registers inside sr_flag_sched.

Verification
REQ-036 The bench SHALL cover reset: after rst_n low then high -> flags=8'h00, flags_n=8'hFF, gnt=0, busy=0.
REQ-037 The bench SHALL cover single set: req=4'b0001, op0=10, idx0=3 -> gnt=4'b0001 for one cycle, then flags=8'h08.
REQ-038 The bench SHALL cover the round-robin sequence: req=4'b1111 held -> gnt order 0001, 0010, 0100, 1000, 0001, spaced two cycles apart.
REQ-039 The bench SHALL cover toggle then clear: flags=8'h08; requester 2 op=11 idx=3 -> flags=8'h00; op=11 again -> flags=8'h08; op=01 -> flags=8'h00.
REQ-040 The bench SHALL cover clr_all collision: flags=8'hF0, requester 1 op=10 idx=0 granted, clr_all=1 on the GRANT edge -> flags=8'h00 (bit 0 not set), ptr=2.
REQ-041 The bench SHALL cover async reset mid-GRANT: rst_n pulsed low during busy=1 -> gnt=0 and flags=0 immediately without waiting for clk; the next request from requester 3 alone is granted normally.

Source files
------------

// File: rtl/sr_flag_sched_pkg.sv
// Shared opcode encoding, FSM state type and the per-flag op helper for sr_flag_sched.
package sr_flag_sched_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Every opcode maps to a defined value, so set+reset never goes X.
  function automatic logic apply_op(input logic [1:0] op, input logic cur);
    logic nxt;
    nxt = cur;
    case (op)
      OP_CLR:  nxt = 1'b0;
      OP_SET:  nxt = 1'b1;
      OP_TGL:  nxt = ~cur;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_rr_arbiter.sv
// Combinational round-robin picker: searches upward from ptr, wrapping modulo NREQ.
module sr_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] winner,
  output logic            any
);

  int j;

  // Walk offsets from farthest to nearest so the closest requester to ptr wins last.
  always_comb begin
    winner = '0;
    j      = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        winner    = '0;
        winner[j] = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/sr_flag_sched.sv
// Round-robin scheduler applying per-requester set/clear/toggle ops to a flag bank.
module sr_flag_sched
  import sr_flag_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IW    = $clog2(NFLAG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] op,
  input  logic [IW*NREQ-1:0] idx,
  input  logic              clr_all,
  output logic [NREQ-1:0]   gnt,
  output logic [NFLAG-1:0]  flags,
  output logic [NFLAG-1:0]  flags_n,
  output logic              busy
);

  localparam int PW = $clog2(NREQ);

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, win_q, win_idx, ptr_inc;
  logic [1:0]      op_q, win_op;
  logic [IW-1:0]   idx_q, win_fidx;
  logic [NREQ-1:0] win_oh;
  logic            any, take;

  sr_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req    (req),
    .ptr    (ptr),
    .winner (win_oh),
    .any    (any)
  );

  // One-hot winner to index, and mux out that requester's op/idx fields.
  always_comb begin
    win_idx  = '0;
    win_op   = OP_HOLD;
    win_fidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) begin
        win_idx  = PW'(i);
        win_op   = op[2*i +: 2];
        win_fidx = idx[IW*i +: IW];
      end
    end
  end

  assign ptr_inc = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (!clr_all && any) begin
          take      = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      win_q <= '0;
      op_q  <= OP_HOLD;
      idx_q <= '0;
    end else if (take) begin
      ptr   <= ptr_inc;
      win_q <= win_idx;
      op_q  <= win_op;
      idx_q <= win_fidx;
    end
  end

  // gnt depends only on state and the captured winner, so async reset kills it at once.
  always_comb begin
    gnt = '0;
    if (state == GRANT) gnt[win_q] = 1'b1;
  end

  assign busy = (state == GRANT);

  // Independent flag registers; an out-of-range idx_q matches none of them.
  for (genvar f = 0; f < NFLAG; f++) begin : g_flag
    logic q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  q <= 1'b0;
      else if (clr_all)                            q <= 1'b0;
      else if (state == GRANT && idx_q == IW'(f))  q <= apply_op(op_q, q);
    end
    assign flags[f] = q;
  end

  assign flags_n = ~flags;

endmodule

// File: tb/tb_sr_flag_sched.sv
// Directed bench for sr_flag_sched with hand-computed expectations.
module tb_sr_flag_sched;

  localparam int NREQ  = 4;
  localparam int NFLAG = 8;
  localparam int IW    = 3;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] op;
  logic [IW*NREQ-1:0] idx;
  logic              clr_all;
  logic [NREQ-1:0]   gnt;
  logic [NFLAG-1:0]  flags;
  logic [NFLAG-1:0]  flags_n;
  logic              busy;

  int nchk = 0;
  int nerr = 0;

  sr_flag_sched #(.NREQ(NREQ), .NFLAG(NFLAG), .IW(IW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .op      (op),
    .idx     (idx),
    .clr_all (clr_all),
    .gnt     (gnt),
    .flags   (flags),
    .flags_n (flags_n),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rq(input int r, input logic [1:0] o, input logic [2:0] i);
    op[2*r +: 2]   = o;
    idx[IW*r +: IW] = i;
  endtask

  initial begin
    logic [NREQ-1:0] rr_exp [5];
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    rst_n = 1'b0; req = '0; op = '0; idx = '0; clr_all = 1'b0;
    #1;
    chk("rst_hold_flags_n", 32'(flags_n), 32'hFF);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_flags", 32'(flags), 32'h00);
    chk("rst_flags_n", 32'(flags_n), 32'hFF);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Round-robin with all requesters holding, all ops hold.
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk($sformatf("rr_gnt%0d", n), 32'(gnt), 32'(rr_exp[n]));
      tick();
      chk($sformatf("rr_gap%0d", n), 32'(gnt), 32'h0);
    end
    chk("rr_flags", 32'(flags), 32'h00);
    req = '0;
    tick();

    // Single set: requester 0, set idx 3.
    set_rq(0, 2'b10, 3'd3);
    req = 4'b0001;
    tick();
    chk("set_gnt", 32'(gnt), 32'h1);
    chk("set_busy", 32'(busy), 32'h1);
    chk("set_flags_pre", 32'(flags), 32'h00);
    req = '0;
    tick();
    chk("set_gnt_off", 32'(gnt), 32'h0);
    chk("set_flags", 32'(flags), 32'h08);

    // Toggle, toggle, clear via requester 2 on idx 3.
    set_rq(2, 2'b11, 3'd3);
    req = 4'b0100;
    tick(); chk("tgl1_gnt", 32'(gnt), 32'h4);
    tick(); chk("tgl1_flags", 32'(flags), 32'h00);
    tick(); tick(); chk("tgl2_flags", 32'(flags), 32'h08);
    set_rq(2, 2'b01, 3'd3);
    tick(); tick(); chk("clr_flags", 32'(flags), 32'h00);
    chk("clr_flags_n", 32'(flags_n), 32'hFF);
    req = '0;
    tick();

    // Build flags = F0 through requester 0.
    req = 4'b0001;
    for (int b = 4; b < 8; b++) begin
      set_rq(0, 2'b10, 3'(b));
      tick(); tick();
    end
    req = '0;
    chk("build_f0", 32'(flags), 32'hF0);

    // clr_all on the GRANT edge discards requester 1's set of bit 0.
    set_rq(1, 2'b10, 3'd0);
    req = 4'b0010;
    tick(); chk("coll_gnt", 32'(gnt), 32'h2);
    req = '0; clr_all = 1'b1;
    tick(); chk("coll_flags", 32'(flags), 32'h00);
    chk("coll_busy", 32'(busy), 32'h0);

    // clr_all at an IDLE edge blocks capture; ptr must still be 2.
    op = '0; idx = '0;
    req = 4'b1111;
    tick(); chk("idle_clr_gnt", 32'(gnt), 32'h0);
    chk("idle_clr_busy", 32'(busy), 32'h0);
    clr_all = 1'b0;
    tick(); chk("ptr2_gnt", 32'(gnt), 32'h4);
    req = '0;
    tick();

    // Requester 3 sets bit 1 (ptr wraps to 0 afterwards).
    set_rq(3, 2'b10, 3'd1);
    req = 4'b1000;
    tick(); chk("r3_gnt", 32'(gnt), 32'h8);
    req = '0;
    tick(); chk("r3_flags", 32'(flags), 32'h02);

    // Async reset during GRANT aborts the set of bit 5.
    set_rq(3, 2'b10, 3'd5);
    req = 4'b1000;
    tick(); chk("abort_busy_pre", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_gnt", 32'(gnt), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_flags", 32'(flags), 32'h00);
    chk("abort_flags_n", 32'(flags_n), 32'hFF);
    #2 rst_n = 1'b1;
    tick(); chk("post_rst_gnt", 32'(gnt), 32'h8);
    req = '0;
    tick(); chk("post_rst_flags", 32'(flags), 32'h20);
    chk("post_rst_gnt_off", 32'(gnt), 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
